// File: rtl/floo_axis_flit_unpacker.sv
`default_nettype none
// ============================================================================
// floo_axis_flit_unpacker : splits packed AXI-Stream beats into request and
// response flit FIFOs and tracks the far-end ready flags.
// Optional feature macro: FLOO_UNPACKER_STATS_EN (per-channel push counters).
// Revision: 1.0
// ============================================================================

module floo_axis_unpacker_fifo #(
   parameter int unsigned Width = 64,
   parameter int unsigned Depth = 4,
   localparam int unsigned PtrWidth = $clog2(Depth)
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                push_i,
   input  logic [Width-1:0]    data_i,
   input  logic                pop_i,
   output logic [Width-1:0]    data_o,
   output logic [PtrWidth:0]   count_o
);

   logic [Width-1:0]    mem_q [Depth];
   logic [PtrWidth-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrWidth-1:0] rd_ptr_q, rd_ptr_d;
   logic [PtrWidth:0]   count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_i) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (pop_i) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      // A simultaneous push and pop leaves the occupancy unchanged.
      if (push_i && !pop_i) begin
         count_d = count_q + 1'b1;
      end else if (!push_i && pop_i) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

module floo_axis_flit_unpacker #(
   parameter int unsigned ReqDataWidth = 64,
   parameter int unsigned RspDataWidth = 64,
   parameter int unsigned FifoDepth    = 4,
   localparam int unsigned TdataWidth  = 8 * ((ReqDataWidth + RspDataWidth + 4 + 7) / 8)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic [TdataWidth-1:0]   axis_tdata_i,
   input  logic                    axis_tvalid_i,
   output logic                    axis_tready_o,
   output logic [ReqDataWidth-1:0] req_data_o,
   output logic                    req_valid_o,
   input  logic                    req_ready_i,
   output logic [RspDataWidth-1:0] rsp_data_o,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
`ifdef FLOO_UNPACKER_STATS_EN
   output logic [15:0]             stat_req_cnt_o,
   output logic [15:0]             stat_rsp_cnt_o,
`endif
   output logic                    remote_req_ready_o,
   output logic                    remote_rsp_ready_o
);

   localparam int unsigned CNT_W         = $clog2(FifoDepth) + 1;
   localparam int unsigned RSP_READY_BIT = 0;
   localparam int unsigned RSP_VALID_BIT = 1;
   localparam int unsigned RSP_DATA_LSB  = 2;
   localparam int unsigned REQ_READY_BIT = RspDataWidth + 2;
   localparam int unsigned REQ_VALID_BIT = RspDataWidth + 3;
   localparam int unsigned REQ_DATA_LSB  = RspDataWidth + 4;
   localparam int unsigned PAYLOAD_W     = ReqDataWidth + RspDataWidth + 4;
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FifoDepth);

   logic                    w_accept;
   logic                    w_req_push, w_rsp_push;
   logic                    w_req_pop, w_rsp_pop;
   logic [CNT_W-1:0]        w_req_count, w_rsp_count;
   logic [ReqDataWidth-1:0] w_req_in;
   logic [RspDataWidth-1:0] w_rsp_in;
   logic                    remote_req_ready_q, remote_rsp_ready_q;

   if (TdataWidth > PAYLOAD_W) begin : g_pad
      logic pad_unused;
      assign pad_unused = ^axis_tdata_i[TdataWidth-1:PAYLOAD_W];
   end

   assign w_req_in = axis_tdata_i[REQ_DATA_LSB +: ReqDataWidth];
   assign w_rsp_in = axis_tdata_i[RSP_DATA_LSB +: RspDataWidth];

   // Outputs are forced low while reset is held so no stale flit can escape.
   assign axis_tready_o = !rst_i && (w_req_count < FULL_CNT) && (w_rsp_count < FULL_CNT);
   assign req_valid_o   = !rst_i && (w_req_count != '0);
   assign rsp_valid_o   = !rst_i && (w_rsp_count != '0);

   assign w_accept   = axis_tvalid_i && axis_tready_o;
   assign w_req_push = w_accept && axis_tdata_i[REQ_VALID_BIT];
   assign w_rsp_push = w_accept && axis_tdata_i[RSP_VALID_BIT];
   assign w_req_pop  = req_valid_o && req_ready_i;
   assign w_rsp_pop  = rsp_valid_o && rsp_ready_i;

   floo_axis_unpacker_fifo #(
      .Width (ReqDataWidth),
      .Depth (FifoDepth)
   ) i_req_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_req_push),
      .data_i  (w_req_in),
      .pop_i   (w_req_pop),
      .data_o  (req_data_o),
      .count_o (w_req_count)
   );

   floo_axis_unpacker_fifo #(
      .Width (RspDataWidth),
      .Depth (FifoDepth)
   ) i_rsp_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (w_rsp_push),
      .data_i  (w_rsp_in),
      .pop_i   (w_rsp_pop),
      .data_o  (rsp_data_o),
      .count_o (w_rsp_count)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         remote_req_ready_q <= 1'b0;
         remote_rsp_ready_q <= 1'b0;
      end else if (w_accept) begin
         remote_req_ready_q <= axis_tdata_i[REQ_READY_BIT];
         remote_rsp_ready_q <= axis_tdata_i[RSP_READY_BIT];
      end
   end

   assign remote_req_ready_o = remote_req_ready_q;
   assign remote_rsp_ready_o = remote_rsp_ready_q;

`ifdef FLOO_UNPACKER_STATS_EN
   logic [15:0] stat_req_q, stat_req_d;
   logic [15:0] stat_rsp_q, stat_rsp_d;

   // Saturating push counters.
   always_comb begin
      stat_req_d = stat_req_q;
      stat_rsp_d = stat_rsp_q;
      if (w_req_push && (stat_req_q != 16'hFFFF)) begin
         stat_req_d = stat_req_q + 16'd1;
      end
      if (w_rsp_push && (stat_rsp_q != 16'hFFFF)) begin
         stat_rsp_d = stat_rsp_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stat_req_q <= 16'd0;
         stat_rsp_q <= 16'd0;
      end else begin
         stat_req_q <= stat_req_d;
         stat_rsp_q <= stat_rsp_d;
      end
   end

   assign stat_req_cnt_o = stat_req_q;
   assign stat_rsp_cnt_o = stat_rsp_q;
`endif

endmodule
`default_nettype wire

// File: doc/floo_axis_flit_unpacker.md
FLOO_AXIS_FLIT_UNPACKER -- requirements
Module: floo_axis_flit_unpacker

Interface
REQ-001 SHALL have parameter ReqDataWidth, default 64, giving the request flit payload width in bits with the valid/ready bits stripped.
REQ-002 SHALL have parameter RspDataWidth, default 64, giving the response flit payload width in bits with the valid/ready bits stripped.
REQ-003 SHALL have parameter FifoDepth, default 4, giving entries per channel FIFO; it is a power of two and at least 2.
REQ-004 SHALL derive TdataWidth as 8*ceil((ReqDataWidth+RspDataWidth+4)/8).
REQ-005 SHALL have port clk_i, input, 1, the single clock, rising edge.
REQ-006 SHALL have port rst_i, input, 1, the reset, synchronous and active-high.
REQ-007 SHALL have port axis_tdata_i, input, TdataWidth, the packed beat; from MSB down it holds {req_data, req_valid, req_ready, rsp_data, rsp_valid, rsp_ready}, with zero padding at the top.
REQ-008 SHALL have port axis_tvalid_i, input, 1, the beat valid.
REQ-009 SHALL have port axis_tready_o, output, 1, the beat accept.
REQ-010 SHALL have ports req_data_o (ReqDataWidth), req_valid_o (1) and req_ready_i (1), the request flit output handshake.
REQ-011 SHALL have ports rsp_data_o (RspDataWidth), rsp_valid_o (1) and rsp_ready_i (1), the response flit output handshake.
REQ-012 SHALL have ports remote_req_ready_o (1) and remote_rsp_ready_o (1), the last ready flags received from the far-end bridge.

Function
REQ-013 SHALL accept a beat when axis_tvalid_i and axis_tready_o are both high on a rising edge.
REQ-014 SHALL drive axis_tready_o = (req_count < FifoDepth) && (rsp_count < FifoDepth), computed from registered counts only, with no same-cycle pop bypass.
REQ-015 SHALL, on an accepted beat with req_valid=1, push req_data into the request FIFO, and with rsp_valid=1 push rsp_data into the response FIFO; both pushes may occur on the same edge.
REQ-016 SHALL push nothing for a channel whose valid bit is 0.
REQ-017 SHALL accept a beat with both valid bits 0; it updates only the remote ready flags.
REQ-018 SHALL present a pushed flit at the FIFO output no earlier than the cycle after the push, i.e. minimum latency of 1 cycle with no fall-through.
REQ-019 SHALL assert req_valid_o when req_count > 0, with req_data_o showing the oldest entry; a pop occurs on req_valid_o && req_ready_i. The response channel behaves identically.
REQ-020 SHALL, on simultaneous push and pop on one channel, leave that channel's count unchanged and preserve FIFO order.
REQ-021 SHALL use read and write pointers of log2(FifoDepth) bits that wrap modulo FifoDepth, and a count of log2(FifoDepth)+1 bits.
REQ-022 SHALL keep req_data_o and rsp_data_o stable while valid is high and ready is low.
REQ-023 SHALL load remote_req_ready_o and remote_rsp_ready_o from the req_ready and rsp_ready bits of every accepted beat, and hold them otherwise.
REQ-024 SHALL keep the two channels independent, so a stalled channel never reorders or drops flits on the other.

Reset
REQ-025 SHALL, while rst_i is high at a rising edge, clear all pointers and counts and clear remote_req_ready_o and remote_rsp_ready_o to 0.
REQ-026 SHALL hold req_valid_o=0, rsp_valid_o=0 and axis_tready_o=0 during reset and drive axis_tready_o=1 on the first cycle after rst_i falls.
REQ-027 SHALL discard FIFO contents on a reset asserted mid-operation, without emitting partial or stale flits afterward.

Configuration
REQ-028 SHALL, with macro FLOO_UNPACKER_STATS_EN defined, add outputs stat_req_cnt_o[15:0] and stat_rsp_cnt_o[15:0]; each increments once per pushed flit of its channel, saturates at 16'hFFFF and resets to 0.
REQ-029 SHALL, without FLOO_UNPACKER_STATS_EN, omit those ports and their counters entirely, with all other behaviour identical.

Verification
REQ-030 SHALL cover reset: hold rst_i for 3 cycles with axis_tvalid_i=1 -> no push, both valids 0, remote flags 0, tready 1 the cycle after release.
REQ-031 SHALL cover single beat: req_valid=1, req_data=64'hA5, rsp_valid=0, req_ready=1 -> req_valid_o=1 with 64'hA5 the next cycle, rsp_valid_o=0, remote_req_ready_o=1.
REQ-032 SHALL cover backpressure: FifoDepth=4, req_ready_i=0, send 4 request beats -> tready=0 after the 4th; one pop -> tready=1 the next cycle and order 1,2,3,4 preserved.
REQ-033 SHALL cover dual push: one beat with both valid bits set (req 0x11, rsp 0x22) -> both outputs valid the next cycle with the correct data.
REQ-034 SHALL cover wrap-around: 10 request flits with values 0..9 at full throughput and req_ready_i=1 -> output 0..9 in order with no gaps after the first-cycle latency.
REQ-035 SHALL cover stats: with FLOO_UNPACKER_STATS_EN, 70000 request pushes -> stat_req_cnt_o=16'hFFFF, and stat_rsp_cnt_o unchanged.
